// File: rtl/int_alu_pkg.sv
// Shared types and constants for the 16-lane integer ALU.
// Saturating ADD/SUB is selected by defining INT_ALU_SAT_EN.
package int_alu_pkg;

  localparam int LANE_W = 16;
  localparam int LANES = 16;
  localparam int MUL_LANES_PER_CYC = 4;
  localparam int DATA_W = LANE_W * LANES;

  localparam logic [11:0] OFF_SRC1 = 12'h000;
  localparam logic [11:0] OFF_SRC2 = 12'h001;
  localparam logic [11:0] OFF_CMD = 12'h003;

  typedef enum logic [7:0] {
    OP_ADD = 8'h10,
    OP_SUB = 8'h11,
    OP_MUL = 8'h12,
    OP_MAC = 8'h13
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_valid(input logic [7:0] c);
    return (c >= 8'h10) && (c <= 8'h13);
  endfunction

  function automatic logic is_mul(input opcode_t o);
    return (o == OP_MUL) || (o == OP_MAC);
  endfunction

endpackage

// File: rtl/int_alu_lane.sv
// One 16-bit ALU lane: add/sub (wrap or saturate), mul and mac.
// INT_ALU_SAT_EN selects signed saturation for ADD/SUB.
module int_alu_lane
  import int_alu_pkg::*;
#(
  parameter bit HAS_MUL = 1'b1
) (
  input  opcode_t           op,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [LANE_W-1:0] acc,
  output logic [LANE_W-1:0] y
);

  logic [LANE_W-1:0] prod;
  logic [LANE_W-1:0] sum;
  logic [LANE_W-1:0] dif;

  if (HAS_MUL) begin : g_mul
    assign prod = a * b;
  end else begin : g_nomul
    assign prod = '0;
  end

`ifdef INT_ALU_SAT_EN
  logic [LANE_W:0] sx;
  logic [LANE_W:0] dx;

  assign sx = {a[LANE_W-1], a} + {b[LANE_W-1], b};
  assign dx = {a[LANE_W-1], a} - {b[LANE_W-1], b};

  // Top two bits disagree only on signed overflow.
  always_comb begin
    sum = sx[LANE_W-1:0];
    dif = dx[LANE_W-1:0];
    if (sx[LANE_W] != sx[LANE_W-1])
      sum = sx[LANE_W] ? 16'h8000 : 16'h7FFF;
    if (dx[LANE_W] != dx[LANE_W-1])
      dif = dx[LANE_W] ? 16'h8000 : 16'h7FFF;
  end
`else
  assign sum = a + b;
  assign dif = a - b;
`endif

  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD: y = sum;
      OP_SUB: y = dif;
      OP_MUL: y = prod;
      OP_MAC: y = prod + acc;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/integer_alu.sv
// Bus-mapped 16x16-bit SIMD ALU; MUL/MAC run 4 lanes per cycle.
// Build with INT_ALU_SAT_EN for saturating ADD/SUB.
module integer_alu
  import int_alu_pkg::*;
#(
  parameter logic [3:0] MODULE_ID = 4'h5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       address,
  input  logic              nWrite,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] IntDataOut,
  output logic [7:0]        StatusOut
);

  logic hit;
  logic cmd_wr;
  logic cmd_q;
  logic launch;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] work;
  logic [DATA_W-1:0] work_nx;
  logic [DATA_W-1:0] add_out;
  state_t state;
  opcode_t op;
  logic [1:0] chunk;
  logic busy;
  logic done;
  logic err;
  logic [LANE_W-1:0] y [LANES];

  assign hit = !nWrite && (address[15:12] == MODULE_ID);
  assign cmd_wr = hit && (address[11:0] == OFF_CMD);
  assign launch = cmd_wr && !cmd_q;

  // The first four lanes double as the chunked multiplier datapath.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam bit MUL = (i < MUL_LANES_PER_CYC);
    logic [3:0] idx;
    assign idx = MUL ? {chunk, 2'(i)} : 4'(i);
    int_alu_lane #(.HAS_MUL(MUL)) u_lane (
      .op  (op),
      .a   (src1[32'(idx)*LANE_W +: LANE_W]),
      .b   (src2[32'(idx)*LANE_W +: LANE_W]),
      .acc (result[32'(idx)*LANE_W +: LANE_W]),
      .y   (y[i])
    );
  end

  always_comb begin
    add_out = '0;
    work_nx = work;
    for (int i = 0; i < LANES; i++)
      add_out[i*LANE_W +: LANE_W] = y[i];
    for (int j = 0; j < MUL_LANES_PER_CYC; j++)
      work_nx[32'({chunk, 2'(j)})*LANE_W +: LANE_W] = y[j];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= ST_IDLE;
      op     <= OP_ADD;
      src1   <= '0;
      src2   <= '0;
      result <= '0;
      work   <= '0;
      chunk  <= '0;
      cmd_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      cmd_q <= cmd_wr;
      unique case (state)
        ST_IDLE: begin
          if (hit && address[11:0] == OFF_SRC1)
            src1 <= DataIn;
          if (hit && address[11:0] == OFF_SRC2)
            src2 <= DataIn;
          if (launch) begin
            if (op_valid(DataIn[7:0])) begin
              op    <= opcode_t'(DataIn[7:0]);
              chunk <= '0;
              state <= ST_EXEC;
              busy  <= 1'b1;
              done  <= 1'b0;
              err   <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (launch)
            err <= 1'b1;
          if (is_mul(op)) begin
            work  <= work_nx;
            chunk <= chunk + 2'd1;
            if (chunk == 2'd3) begin
              result <= work_nx;
              state  <= ST_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end else begin
            result <= add_out;
            state  <= ST_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (launch)
            err <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign IntDataOut = result;
  assign StatusOut = {5'b0, err, done, busy};

endmodule

// File: tb/tb_integer_alu.sv
// Directed, table-driven bench for integer_alu.
// Honours INT_ALU_SAT_EN for the saturation vectors.
module tb_integer_alu;
  import int_alu_pkg::*;

  logic Clk;
  logic Reset;
  logic [15:0] address;
  logic nWrite;
  logic [255:0] DataIn;
  logic [255:0] IntDataOut;
  logic [7:0] StatusOut;

  int checks;
  int errors;

  integer_alu #(.MODULE_ID(4'h5)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .address    (address),
    .nWrite     (nWrite),
    .DataIn     (DataIn),
    .IntDataOut (IntDataOut),
    .StatusOut  (StatusOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]   op;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] exp;
    int           lat;
  } vec_t;

  vec_t v [10];

  localparam logic [255:0] SQ_IN = {
    16'h0010, 16'h000F, 16'h000E, 16'h000D,
    16'h000C, 16'h000B, 16'h000A, 16'h0009,
    16'h0008, 16'h0007, 16'h0006, 16'h0005,
    16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [255:0] SQ_OUT = {
    16'h0100, 16'h00E1, 16'h00C4, 16'h00A9,
    16'h0090, 16'h0079, 16'h0064, 16'h0051,
    16'h0040, 16'h0031, 16'h0024, 16'h0019,
    16'h0010, 16'h0009, 16'h0004, 16'h0001};
  localparam logic [255:0] SQ_MAC = {
    16'h0200, 16'h01C2, 16'h0188, 16'h0152,
    16'h0120, 16'h00F2, 16'h00C8, 16'h00A2,
    16'h0080, 16'h0062, 16'h0048, 16'h0032,
    16'h0020, 16'h0012, 16'h0008, 16'h0002};
  localparam logic [255:0] SQ_DBL = {
    16'h0020, 16'h001E, 16'h001C, 16'h001A,
    16'h0018, 16'h0016, 16'h0014, 16'h0012,
    16'h0010, 16'h000E, 16'h000C, 16'h000A,
    16'h0008, 16'h0006, 16'h0004, 16'h0002};
  localparam logic [255:0] V0_A = 256'h0001_0002_0003_0004;
  localparam logic [255:0] V0_B = 256'h0008_0007_0006_0005;
  localparam logic [255:0] V0_R = 256'h0009_0009_0009_0009;

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [11:0] off, input logic [255:0] d);
    @(negedge Clk);
    address = {4'h5, off};
    DataIn = d;
    nWrite = 1'b0;
    @(negedge Clk);
    nWrite = 1'b1;
  endtask

  task automatic launch(input logic [7:0] op);
    wr(OFF_CMD, {248'h0, op});
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!StatusOut[1] && n < 20) begin
      @(negedge Clk);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [255:0] prev;
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    nWrite = 1'b1;
    address = '0;
    DataIn = '0;

    v[0] = '{8'h10, V0_A, V0_B, V0_R, 1};
    v[1] = '{8'h12, {16{16'h0009}}, {16{16'h0009}},
             {16{16'h0051}}, 4};
    v[2] = '{8'h13, {16{16'h0009}}, {16{16'h0009}},
             {16{16'h00A2}}, 4};
`ifdef INT_ALU_SAT_EN
    v[3] = '{8'h10, 256'h7FFF, 256'h0001, 256'h7FFF, 1};
    v[8] = '{8'h11, {16{16'h8000}}, {16{16'h0001}},
             {16{16'h8000}}, 1};
`else
    v[3] = '{8'h10, 256'h7FFF, 256'h0001, 256'h8000, 1};
    v[8] = '{8'h11, {16{16'h8000}}, {16{16'h0001}},
             {16{16'h7FFF}}, 1};
`endif
    v[4] = '{8'h11, 256'h0004, 256'h0005, 256'hFFFF, 1};
    v[5] = '{8'h12, SQ_IN, SQ_IN, SQ_OUT, 4};
    v[6] = '{8'h13, SQ_IN, SQ_IN, SQ_MAC, 4};
    v[7] = '{8'h12, {16{16'h1234}}, {16{16'h0010}},
             {16{16'h2340}}, 4};
    v[9] = '{8'h10, {16{16'hFFFF}}, {16{16'h0002}},
             {16{16'h0001}}, 1};

    repeat (3) @(negedge Clk);
    chk("reset_result", IntDataOut, '0);
    chk("reset_status", 256'(StatusOut), '0);
    Reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      wr(OFF_SRC1, v[i].a);
      wr(OFF_SRC2, v[i].b);
      launch(v[i].op);
      chk($sformatf("v%0d_busy", i), 256'(StatusOut), 256'h01);
      wait_done(n);
      chk($sformatf("v%0d_lat", i), 256'(n), 256'(v[i].lat));
      chk($sformatf("v%0d_result", i), IntDataOut, v[i].exp);
      chk($sformatf("v%0d_status", i), 256'(StatusOut), 256'h02);
    end

    prev = IntDataOut;
    launch(8'h1F);
    chk("badop_err", 256'(StatusOut[2]), 256'd1);
    chk("badop_busy", 256'(StatusOut[0]), 256'd0);
    chk("badop_result", IntDataOut, prev);
    repeat (2) @(negedge Clk);
    chk("badop_idle", 256'(StatusOut[0]), 256'd0);

    wr(OFF_SRC1, V0_A);
    wr(OFF_SRC2, V0_B);
    @(negedge Clk);
    address = {4'h5, OFF_CMD};
    DataIn = 256'h10;
    nWrite = 1'b0;
    repeat (3) @(negedge Clk);
    nWrite = 1'b1;
    chk("hold_result", IntDataOut, V0_R);
    chk("hold_status", 256'(StatusOut), 256'h02);
    repeat (2) @(negedge Clk);
    chk("hold_no_relaunch", 256'(StatusOut), 256'h02);

    wr(OFF_SRC1, SQ_IN);
    wr(OFF_SRC2, SQ_IN);
    launch(8'h12);
    wr(OFF_SRC1, {16{16'hFFFF}});
    launch(8'h10);
    wait_done(n);
    chk("busywr_result", IntDataOut, SQ_OUT);
    chk("busywr_status", 256'(StatusOut), 256'h06);
    launch(8'h10);
    wait_done(n);
    chk("busywr_src1_kept", IntDataOut, SQ_DBL);
    chk("busywr_status2", 256'(StatusOut), 256'h02);

    launch(8'h12);
    @(negedge Clk);
    chk("rst_pre_busy", 256'(StatusOut), 256'h01);
    Reset = 1'b1;
    #1;
    chk("rst_result", IntDataOut, '0);
    chk("rst_status", 256'(StatusOut), '0);
    @(negedge Clk);
    Reset = 1'b0;
    wr(OFF_SRC1, V0_A);
    wr(OFF_SRC2, V0_B);
    launch(8'h10);
    wait_done(n);
    chk("rst_add_lat", 256'(n), 256'd1);
    chk("rst_add_result", IntDataOut, V0_R);
    chk("rst_add_status", 256'(StatusOut), 256'h02);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
